// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and default sizing for the arbiter, RS and ROB.
// The NUM_CDB / NUM_FU macros are kept for downstream sizing code.
`ifndef CDB_ARBITER_PKG_SV
`define CDB_ARBITER_PKG_SV

`ifndef NUM_CDB
`define NUM_CDB 2
`endif

`ifndef NUM_FU
`define NUM_FU 4
`endif

package cdb_arbiter_pkg;

    localparam int NUM_CDB_DEF = `NUM_CDB;
    localparam int NUM_FU_DEF  = `NUM_FU;
    localparam int DATA_W      = 32;
    localparam int ROB_IDX_W   = 5;
    localparam int PRN_W       = 6;

    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PRN_W-1:0]     dest_prn;
        logic                 br_taken;
        logic                 exception;
    } ex_complete_t;

endpackage

`endif

// File: rtl/cdb_arbiter_if.sv
// FU-to-CDB bundle: early requests and results in, grants and lanes out.
// master = functional-unit side, slave = arbiter side.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_FU_DEF,
    parameter int NUM_CDB = NUM_CDB_DEF,
    parameter int IDX_W   = $clog2(NUM_REQ)
);

    logic         [NUM_REQ-1:0] fu_req;
    logic         [NUM_REQ-1:0] fu_grant;
    logic         [NUM_REQ-1:0] fu_done;
    data_t        [NUM_REQ-1:0] fu_result;
    ex_complete_t [NUM_REQ-1:0] fu_meta;

    logic                      [NUM_CDB-1:0] cdb_valid;
    data_t                     [NUM_CDB-1:0] cdb_data;
    ex_complete_t              [NUM_CDB-1:0] cdb_meta;
    logic [NUM_CDB-1:0][IDX_W-1:0]           cdb_src;
    logic                                    protocol_err;

    modport master (
        output fu_req,
        output fu_done,
        output fu_result,
        output fu_meta,
        input  fu_grant,
        input  cdb_valid,
        input  cdb_data,
        input  cdb_meta,
        input  cdb_src,
        input  protocol_err
    );

    modport slave (
        input  fu_req,
        input  fu_done,
        input  fu_result,
        input  fu_meta,
        output fu_grant,
        output cdb_valid,
        output cdb_data,
        output cdb_meta,
        output cdb_src,
        output protocol_err
    );

endinterface

// File: rtl/cdb_arbiter_rr_select.sv
// Rotating priority pick: up to NUM_CDB grants starting at ptr_i,
// k-th grant in scan order lands on lane k.
module cdb_arbiter_rr_select #(
    parameter int NUM_REQ = 4,
    parameter int NUM_CDB = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [IDX_W-1:0]              ptr_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [NUM_CDB-1:0]            lane_vld_o,
    output logic [NUM_CDB-1:0][IDX_W-1:0] lane_idx_o,
    output logic [IDX_W-1:0]              next_ptr_o
);

    int cnt;
    int pos;

    always_comb begin
        grant_o    = '0;
        lane_vld_o = '0;
        lane_idx_o = '0;
        next_ptr_o = ptr_i;
        cnt        = 0;
        pos        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(ptr_i) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            for (int r = 0; r < NUM_REQ; r++) begin
                if (r == pos && req_i[r] && cnt < NUM_CDB) begin
                    grant_o[r] = 1'b1;
                    for (int k = 0; k < NUM_CDB; k++) begin
                        if (k == cnt) begin
                            lane_vld_o[k] = 1'b1;
                            lane_idx_o[k] = IDX_W'(r);
                        end
                    end
                    // last grant in scan order wins the pointer
                    next_ptr_o = (r == NUM_REQ - 1) ? '0 : IDX_W'(r + 1);
                    cnt        = cnt + 1;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: same-cycle grant on early request, lane booking,
// next-cycle broadcast of the booked FU's result, sticky protocol check.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_FU_DEF,
    parameter int NUM_CDB = NUM_CDB_DEF,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input logic           clock,
    input logic           reset_n,
    cdb_arbiter_if.slave  bus
);

    logic [IDX_W-1:0]              rr_ptr_q;
    logic [IDX_W-1:0]              rr_ptr_d;
    logic [NUM_CDB-1:0]            lane_valid_q;
    logic [NUM_CDB-1:0]            lane_valid_d;
    logic [NUM_CDB-1:0][IDX_W-1:0] lane_src_q;
    logic [NUM_CDB-1:0][IDX_W-1:0] lane_src_d;
    logic                          err_q;
    logic                          err_d;

    logic [NUM_REQ-1:0]            pick_grant;
    logic [IDX_W-1:0]              pick_ptr;
    logic [NUM_CDB-1:0]            lane_done;
    logic [NUM_REQ-1:0]            booked;
    logic                          miss;
    logic                          unsol;

    cdb_arbiter_rr_select #(
        .NUM_REQ (NUM_REQ),
        .NUM_CDB (NUM_CDB),
        .IDX_W   (IDX_W)
    ) u_sel (
        .req_i      (bus.fu_req),
        .ptr_i      (rr_ptr_q),
        .grant_o    (pick_grant),
        .lane_vld_o (lane_valid_d),
        .lane_idx_o (lane_src_d),
        .next_ptr_o (pick_ptr)
    );

    // grants must read zero while held in reset
    assign bus.fu_grant = reset_n ? pick_grant : '0;

    assign rr_ptr_d = (|pick_grant) ? pick_ptr : rr_ptr_q;

    always_comb begin
        lane_done = '0;
        booked    = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            lane_done[k] = bus.fu_done[lane_src_q[k]];
            for (int i = 0; i < NUM_REQ; i++) begin
                if (lane_valid_q[k] && lane_src_q[k] == IDX_W'(i)) begin
                    booked[i] = 1'b1;
                end
            end
        end
    end

    assign miss  = |(lane_valid_q & ~lane_done);
    assign unsol = |(bus.fu_done & ~booked);
    assign err_d = err_q | miss | unsol;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q     <= '0;
            lane_valid_q <= '0;
            lane_src_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lane_valid_q <= lane_valid_d;
            lane_src_q   <= lane_src_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        bus.cdb_valid = '0;
        bus.cdb_data  = '0;
        bus.cdb_meta  = '0;
        bus.cdb_src   = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            bus.cdb_valid[k] = lane_valid_q[k] & lane_done[k];
            if (bus.cdb_valid[k]) begin
                bus.cdb_data[k] = bus.fu_result[lane_src_q[k]];
                bus.cdb_meta[k] = bus.fu_meta[lane_src_q[k]];
            end
            if (lane_valid_q[k]) begin
                bus.cdb_src[k] = lane_src_q[k];
            end
        end
    end

    assign bus.protocol_err = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a round-robin reference model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int NC = 2;
    localparam int MW = $bits(ex_complete_t);

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    cdb_arbiter_if #(.NUM_REQ(NR), .NUM_CDB(NC)) bus();

    cdb_arbiter #(.NUM_REQ(NR), .NUM_CDB(NC)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int          m_ptr;
    bit          m_lv[NC];
    int          m_ls[NC];
    bit          m_err;
    logic [NR-1:0] pend;
    int          waitc[NR];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_ptr = 0;
        m_err = 1'b0;
        pend  = '0;
        for (int k = 0; k < NC; k++) begin
            m_lv[k] = 1'b0;
            m_ls[k] = 0;
        end
        for (int i = 0; i < NR; i++) waitc[i] = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n     = 1'b0;
        bus.fu_req  = '1;
        bus.fu_done = '0;
        #1;
        chk("rst_grant", bus.fu_grant, '0);
        chk("rst_cdb_valid", bus.cdb_valid, '0);
        chk("rst_cdb_data", bus.cdb_data, '0);
        chk("rst_cdb_meta", bus.cdb_meta, '0);
        chk("rst_cdb_src", bus.cdb_src, '0);
        chk("rst_err", bus.protocol_err, 1'b0);
        model_clear();
        @(negedge clock);
        bus.fu_req = '0;
        reset_n    = 1'b1;
    endtask

    task automatic cycle(input logic [NR-1:0] req,
                         input logic [NR-1:0] drop,
                         input logic [NR-1:0] extra);
        logic [NR-1:0] g;
        logic [NR-1:0] done;
        logic [31:0]   r;
        data_t         res[NR];
        ex_complete_t  met[NR];
        int            ln[NC];
        int            nl;
        int            idx;
        bit            v;
        bit            b;
        @(negedge clock);
        bus.fu_req = req;
        done = '0;
        for (int k = 0; k < NC; k++) begin
            if (m_lv[k]) done[m_ls[k]] = 1'b1;
        end
        done = (done & ~drop) | extra;
        bus.fu_done = done;
        for (int i = 0; i < NR; i++) begin
            res[i] = $urandom;
            r      = $urandom;
            met[i] = r[MW-1:0];
            bus.fu_result[i] = res[i];
            bus.fu_meta[i]   = met[i];
        end
        #1;
        g  = '0;
        nl = 0;
        for (int k = 0; k < NC; k++) ln[k] = 0;
        for (int i = 0; i < NR; i++) begin
            idx = (m_ptr + i) % NR;
            if (req[idx] && nl < NC) begin
                g[idx] = 1'b1;
                ln[nl] = idx;
                nl++;
            end
        end
        chk("grant", bus.fu_grant, g);
        for (int k = 0; k < NC; k++) begin
            v = m_lv[k] && done[m_ls[k]];
            chk($sformatf("cdb_valid%0d", k), bus.cdb_valid[k], v);
            chk($sformatf("cdb_data%0d", k), bus.cdb_data[k],
                v ? res[m_ls[k]] : '0);
            chk($sformatf("cdb_meta%0d", k), bus.cdb_meta[k],
                v ? met[m_ls[k]] : '0);
            chk($sformatf("cdb_src%0d", k), bus.cdb_src[k],
                m_lv[k] ? m_ls[k] : 0);
        end
        chk("protocol_err", bus.protocol_err, m_err);
        for (int i = 0; i < NR; i++) begin
            if (req[i]) begin
                if (bus.fu_grant[i]) begin
                    chk($sformatf("wait_bound%0d", i), waitc[i] <= 1, 1);
                    waitc[i] = 0;
                end else begin
                    waitc[i]++;
                end
            end else begin
                waitc[i] = 0;
            end
        end
        for (int k = 0; k < NC; k++) begin
            if (m_lv[k] && !done[m_ls[k]]) m_err = 1'b1;
        end
        for (int i = 0; i < NR; i++) begin
            b = 1'b0;
            for (int k = 0; k < NC; k++) begin
                if (m_lv[k] && m_ls[k] == i) b = 1'b1;
            end
            if (done[i] && !b) m_err = 1'b1;
        end
        if (nl > 0) m_ptr = (ln[nl-1] + 1) % NR;
        for (int k = 0; k < NC; k++) begin
            m_lv[k] = (k < nl);
            m_ls[k] = (k < nl) ? ln[k] : 0;
        end
        pend = req & ~g;
    endtask

    initial begin
        logic [NR-1:0] req;
        logic [31:0]   r;
        bus.fu_req    = '0;
        bus.fu_done   = '0;
        bus.fu_result = '0;
        bus.fu_meta   = '0;
        model_clear();
        do_reset();

        // oversubscription then single mult, wrap-around, back-to-back
        cycle(4'b1111, '0, '0);
        cycle(4'b1100, '0, '0);
        cycle(4'b0000, '0, '0);
        cycle(4'b0100, '0, '0);
        cycle(4'b0000, '0, '0);
        cycle(4'b1001, '0, '0);
        cycle(4'b0000, '0, '0);
        cycle(4'b0100, '0, '0);
        cycle(4'b0100, '0, '0);
        cycle(4'b0000, '0, '0);

        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset();
            r = $urandom;
            if (c % 3 == 0) req = pend | (r[3:0] & r[7:4]);
            else            req = pend | r[3:0];
            cycle(req, '0, '0);
        end
        cycle(4'b0000, '0, '0);

        // missed completion after grant
        do_reset();
        cycle(4'b0010, '0, '0);
        cycle(4'b0000, 4'b0010, '0);
        cycle(4'b0000, '0, '0);
        cycle(4'b0000, '0, '0);
        cycle(4'b0101, '0, '0);
        cycle(4'b0000, '0, '0);

        // unsolicited completion
        do_reset();
        cycle(4'b0000, '0, 4'b1000);
        cycle(4'b0000, '0, '0);
        cycle(4'b0000, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
